inst_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the instruction decoder.
- Owns the PC and fetches 32-bit instruction words from instruction memory over a req/gnt/rvalid interface.
- Buffers fetched words in a small FIFO and presents {pc, inst} pairs to the decoder over a valid/ready handshake.
- Accepts redirects (branch/jump targets from execute), which flush buffered and in-flight fetches.

---
 rtl/inst_fetch_unit.sv | 124 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC owner and instruction fetcher feeding the decoder through a small FIFO.
// Define IF_MISALIGN_FAULT_EN to add the sticky fetch_fault output for misaligned redirects.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
`ifdef IF_MISALIGN_FAULT_EN
  ,
  output logic        fetch_fault
`endif
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

  state_t          r_state, w_state_next;
  logic [31:0]     r_pc, w_pc_next, r_addr, w_target;
  logic            r_kill;
  logic [31:0]     r_fifo_pc[BUF_DEPTH];
  logic [31:0]     r_fifo_inst[BUF_DEPTH];
  logic [AW-1:0]   r_rptr, r_wptr;
  logic [CW-1:0]   r_count, w_count_next;
  logic            w_push, w_pop, w_credit, w_fault, w_fault_next;

`ifdef IF_MISALIGN_FAULT_EN
  logic r_fault;
  assign w_fault_next = redirect_valid ? (redirect_pc[1:0] != 2'b00) : r_fault;
  assign w_fault      = r_fault;
  assign fetch_fault  = r_fault;
  // sticky misalignment fault, cleared only by an aligned redirect
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_fault <= 1'b0;
    else        r_fault <= w_fault_next;
`else
  assign w_fault      = 1'b0;
  assign w_fault_next = 1'b0;
`endif

  assign w_target     = redirect_pc & 32'hFFFF_FFFC;
  assign imem_req     = r_state == REQ;
  assign imem_addr    = r_addr;
  assign out_valid    = (r_count != '0) && !w_fault;
  assign out_pc       = r_fifo_pc[r_rptr];
  assign out_inst     = r_fifo_inst[r_rptr];
  assign w_pop        = out_valid && out_ready;
  assign w_push       = (r_state == WAIT) && imem_rvalid && !redirect_valid;
  assign w_count_next = redirect_valid ? '0 : r_count + CW'(w_push) - CW'(w_pop);
  // the single outstanding slot is free whenever a new request is launched
  assign w_credit     = (w_count_next < CW'(BUF_DEPTH)) && !w_fault_next;

  // next state and next PC; a redirect always overrides the PC
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    case (r_state)
      IDLE:    w_state_next = w_credit ? REQ : IDLE;
      REQ:     if (imem_gnt) begin
                 w_state_next = (redirect_valid || r_kill) ? DISCARD : WAIT;
                 w_pc_next    = (redirect_valid || r_kill) ? r_pc : r_pc + 32'd4;
               end
      WAIT:    w_state_next = imem_rvalid ? ((!redirect_valid && w_credit) ? REQ : IDLE)
                                          : (redirect_valid ? DISCARD : WAIT);
      DISCARD: w_state_next = imem_rvalid ? ((!redirect_valid && w_credit) ? REQ : IDLE) : DISCARD;
      default: w_state_next = IDLE;
    endcase
    if (redirect_valid) w_pc_next = w_target;
  end

  // control registers; the request address is latched only when a new request starts
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= '0;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_kill  <= (r_state == REQ && !imem_gnt) && (r_kill || redirect_valid);
      if (w_state_next == REQ && r_state != REQ) r_addr <= w_pc_next;
    end

  // output FIFO of {pc, inst}; a redirect empties it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_fifo_pc[i]   <= '0;
        r_fifo_inst[i] <= '0;
      end
    end else begin
      r_count <= w_count_next;
      if (redirect_valid) begin
        r_rptr <= '0;
        r_wptr <= '0;
      end else begin
        if (w_pop) r_rptr <= r_rptr + AW'(1);
        if (w_push) begin
          r_fifo_pc[r_wptr]   <= r_addr;
          r_fifo_inst[r_wptr] <= imem_rdata;
          r_wptr              <= r_wptr + AW'(1);
        end
      end
    end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && r_count == CW'(BUF_DEPTH)));
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed checks of fetch, credit stall, redirects and PC wrap.
module tb_inst_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_pc, out_inst;
  logic        gnt_en = 1'b1;
  int          lat = 1;
  int          r_cnt;
  logic [31:0] r_rd;
  logic [31:0] addr_q[$], pc_q[$], inst_q[$];
  int          n_tests = 0, n_fail = 0;
  bit          seen;
`ifdef IF_MISALIGN_FAULT_EN
  logic        fetch_fault;
`endif

  inst_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
`ifdef IF_MISALIGN_FAULT_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign imem_gnt    = imem_req && gnt_en;
  assign imem_rvalid = r_cnt == 1;
  assign imem_rdata  = r_rd;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= 0;
      r_rd  <= '0;
    end else if (imem_req && imem_gnt) begin
      r_cnt <= lat;
      r_rd  <= mem(imem_addr);
    end else if (r_cnt != 0) r_cnt <= r_cnt - 1;

  always @(negedge clk)
    if (rst_n) begin
      if (imem_req && imem_gnt) addr_q.push_back(imem_addr);
      if (out_valid && out_ready) begin
        pc_q.push_back(out_pc);
        inst_q.push_back(out_inst);
      end
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    addr_q.delete();
    pc_q.delete();
    inst_q.delete();
  endtask

  task automatic wait_grant(input string tag);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = imem_req && imem_gnt;
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    // reset values
    do_reset();
    chk("rst_req", {31'd0, imem_req}, 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_inst", out_inst, 0);

    // streaming with zero-wait memory
    lat = 1; gnt_en = 1; out_ready = 1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t1_n", {31'd0, addr_q.size() >= 4 && pc_q.size() >= 4}, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", addr_q[i], 32'(i * 4));
      chk("t1_pc", pc_q[i], 32'(i * 4));
      chk("t1_inst", inst_q[i], mem(32'(i * 4)));
    end

    // decoder stall: exactly BUF_DEPTH fetches, then resume at 0x8
    do_reset();
    out_ready = 0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t2_grants", addr_q.size(), 2);
    chk("t2_req", {31'd0, imem_req}, 0);
    chk("t2_valid", {31'd0, out_valid}, 1);
    chk("t2_head", out_inst, mem(0));
    @(posedge clk); #1 out_ready = 1;
    repeat (10) @(negedge clk);
    chk("t2_addr2", addr_q[2], 32'h8);
    chk("t2_pop0", pc_q[0], 32'h0);
    chk("t2_pop1", pc_q[1], 32'h4);
    chk("t2_pop2", pc_q[2], 32'h8);

    // redirect while waiting for data
    do_reset();
    lat = 3; out_ready = 1;
    rst_n = 1'b1;
    wait_grant("t3_grant");
    @(posedge clk); #1 redirect_valid = 1; redirect_pc = 32'h100;
    @(posedge clk); #1 redirect_valid = 0;
    repeat (15) @(negedge clk);
    chk("t3_addr", addr_q[1], 32'h100);
    chk("t3_pc", pc_q[0], 32'h100);
    chk("t3_inst", inst_q[0], mem(32'h100));

    // grant withheld, redirect mid-request
    do_reset();
    lat = 1; gnt_en = 0;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = imem_req;
    end
    chk("t4_req", {31'd0, seen}, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 redirect_valid = (i == 1); redirect_pc = 32'h200;
      @(negedge clk);
      chk("t4_hold", imem_addr, 32'h0);
    end
    @(posedge clk); #1 redirect_valid = 0; gnt_en = 1;
    repeat (10) @(negedge clk);
    chk("t4_addr0", addr_q[0], 32'h0);
    chk("t4_addr1", addr_q[1], 32'h200);
    chk("t4_pc", pc_q[0], 32'h200);

    // redirect, rvalid and pop in one cycle
    do_reset();
    lat = 3; out_ready = 0;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = imem_rvalid && out_valid;
    end
    chk("t5_sync", {31'd0, seen}, 1);
    #1 out_ready = 1; redirect_valid = 1; redirect_pc = 32'h300;
    @(posedge clk); #1 redirect_valid = 0; out_ready = 0;
    addr_q.delete(); pc_q.delete(); inst_q.delete();
    @(negedge clk);
    chk("t5_empty", {31'd0, out_valid}, 0);
    chk("t5_idle", {31'd0, imem_req}, 0);
    out_ready = 1;
    repeat (15) @(negedge clk);
    chk("t5_addr", addr_q[0], 32'h300);
    chk("t5_pc", pc_q[0], 32'h300);

    // redirect from IDLE: request next cycle, PC wraps past the top
    do_reset();
    lat = 1; out_ready = 1;
`ifdef IF_MISALIGN_FAULT_EN
    redirect_pc = 32'hFFFF_FFFC;
`else
    redirect_pc = 32'hFFFF_FFFE;
`endif
    redirect_valid = 1; rst_n = 1'b1;
    @(posedge clk); #1 redirect_valid = 0;
    @(negedge clk);
    chk("t6_req", {31'd0, imem_req}, 1);
    chk("t6_addr", imem_addr, 32'hFFFF_FFFC);
    repeat (10) @(negedge clk);
    chk("t6_wrap", addr_q[1], 32'h0);
    chk("t6_pc", pc_q[0], 32'hFFFF_FFFC);
    chk("t6_inst", inst_q[0], mem(32'hFFFF_FFFC));

`ifdef IF_MISALIGN_FAULT_EN
    do_reset();
    chk("t7_rst", {31'd0, fetch_fault}, 0);
    redirect_pc = 32'h102; redirect_valid = 1; rst_n = 1'b1;
    @(posedge clk); #1 redirect_valid = 0;
    @(negedge clk);
    chk("t7_fault", {31'd0, fetch_fault}, 1);
    repeat (3) @(negedge clk);
    chk("t7_noreq", {31'd0, imem_req}, 0);
    chk("t7_novalid", {31'd0, out_valid}, 0);
    @(posedge clk); #1 redirect_valid = 1; redirect_pc = 32'h104;
    @(posedge clk); #1 redirect_valid = 0;
    @(negedge clk);
    chk("t7_clear", {31'd0, fetch_fault}, 0);
    chk("t7_req", {31'd0, imem_req}, 1);
    chk("t7_addr", imem_addr, 32'h104);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
